// File: rtl/bouncing_box.sv
// Draws a solid square that bounces around the visible area, with a 2-cycle colour/sync pipeline.
// Optional: define BOUNCE_COLOR_CYCLE_EN to step the box colour through an 8-entry palette per bounce.
module bouncing_box #(
    parameter int GRAPHICS_WIDTH   = 1280,
    parameter int GRAPHICS_HEIGHT  = 800,
    parameter int BOX_SIZE         = 64,
    parameter int STEP             = 2,
    parameter int POSITION_REG_MAX = 11,
    parameter int COLOR_BIT_DEPTH  = 4,
    parameter logic [3*COLOR_BIT_DEPTH-1:0] BOX_COLOR = 12'hF80,
    parameter logic H_SYNC_IDLE    = 1'b1,
    parameter logic V_SYNC_IDLE    = 1'b0
) (
    input  logic                        pixel_clock,
    input  logic                        reset_n,
    input  logic [POSITION_REG_MAX:0]   h_position,
    input  logic [POSITION_REG_MAX:0]   v_position,
    input  logic                        visible_area,
    input  logic                        horizontal_sync_in,
    input  logic                        vertical_sync_in,
    output logic [COLOR_BIT_DEPTH-1:0]  vga_r,
    output logic [COLOR_BIT_DEPTH-1:0]  vga_g,
    output logic [COLOR_BIT_DEPTH-1:0]  vga_b,
    output logic                        vga_horizontal_sync,
    output logic                        vga_vertical_sync,
    output logic [7:0]                  bounce_count
);

    localparam int PW = POSITION_REG_MAX + 1;
    localparam int EW = PW + 1;
    localparam int CW = 3 * COLOR_BIT_DEPTH;

    localparam logic [EW-1:0] STEP_E  = EW'(STEP);
    localparam logic [PW-1:0] STEP_P  = PW'(STEP);
    localparam logic [EW-1:0] SIZE_E  = EW'(BOX_SIZE);
    localparam logic [EW-1:0] LIM_X_E = EW'(GRAPHICS_WIDTH - BOX_SIZE);
    localparam logic [PW-1:0] LIM_X_P = PW'(GRAPHICS_WIDTH - BOX_SIZE);
    localparam logic [EW-1:0] LIM_Y_E = EW'(GRAPHICS_HEIGHT - BOX_SIZE);
    localparam logic [PW-1:0] LIM_Y_P = PW'(GRAPHICS_HEIGHT - BOX_SIZE);
    localparam logic [PW-1:0] TICK_V  = PW'(GRAPHICS_HEIGHT);

    // Returns {bounce, next_dir, next_pos}; comparisons use one extra bit so pos+STEP cannot wrap.
    function automatic logic [PW+1:0] axis_next(input logic [PW-1:0] pos, input logic dir,
                                                input logic [EW-1:0] lim_e,
                                                input logic [PW-1:0] lim_p);
        if (!dir) begin
            if (({1'b0, pos} + STEP_E) >= lim_e)
                return {1'b1, 1'b1, lim_p};
            else
                return {1'b0, 1'b0, pos + STEP_P};
        end else begin
            if ({1'b0, pos} <= STEP_E)
                return {1'b1, 1'b0, {PW{1'b0}}};
            else
                return {1'b0, 1'b1, pos - STEP_P};
        end
    endfunction

    logic [PW-1:0] box_x, box_y;
    logic          dir_x, dir_y;
    logic [PW+1:0] next_x, next_y;
    logic          frame_tick, bounce, in_box;
    logic [CW-1:0] box_color;

    assign frame_tick = (v_position == TICK_V) && (h_position == '0);
    assign next_x     = axis_next(box_x, dir_x, LIM_X_E, LIM_X_P);
    assign next_y     = axis_next(box_y, dir_y, LIM_Y_E, LIM_Y_P);
    assign bounce     = next_x[PW+1] | next_y[PW+1];

    assign in_box = ({1'b0, h_position} >= {1'b0, box_x}) &&
                    ({1'b0, h_position} <  ({1'b0, box_x} + SIZE_E)) &&
                    ({1'b0, v_position} >= {1'b0, box_y}) &&
                    ({1'b0, v_position} <  ({1'b0, box_y} + SIZE_E));

    // A corner hit bounces both axes on one tick but counts as a single event.
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            box_x        <= '0;
            box_y        <= '0;
            dir_x        <= 1'b0;
            dir_y        <= 1'b0;
            bounce_count <= 8'd0;
        end else if (frame_tick) begin
            box_x <= next_x[PW-1:0];
            dir_x <= next_x[PW];
            box_y <= next_y[PW-1:0];
            dir_y <= next_y[PW];
            if (bounce)
                bounce_count <= bounce_count + 8'd1;
        end
    end

`ifdef BOUNCE_COLOR_CYCLE_EN
    logic [2:0] palette_idx;

    function automatic logic [CW-1:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    return BOX_COLOR;
            3'd1:    return CW'(12'h0F0);
            3'd2:    return CW'(12'h00F);
            3'd3:    return CW'(12'hFF0);
            3'd4:    return CW'(12'h0FF);
            3'd5:    return CW'(12'hF0F);
            3'd6:    return CW'(12'hFFF);
            default: return CW'(12'hF00);
        endcase
    endfunction

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n)
            palette_idx <= 3'd0;
        else if (frame_tick && bounce)
            palette_idx <= palette_idx + 3'd1;
    end

    assign box_color = palette(palette_idx);
`else
    assign box_color = BOX_COLOR;
`endif

    // Stage 1: hit test against the pre-update position, capture visibility and syncs.
    logic in_box_p1, vld_p1, hsync_p1, vsync_p1;

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            in_box_p1 <= 1'b0;
            vld_p1    <= 1'b0;
            hsync_p1  <= H_SYNC_IDLE;
            vsync_p1  <= V_SYNC_IDLE;
        end else begin
            in_box_p1 <= in_box;
            vld_p1    <= visible_area;
            hsync_p1  <= horizontal_sync_in;
            vsync_p1  <= vertical_sync_in;
        end
    end

    // Stage 2: colour select with blanking, syncs aligned to colour.
    logic [CW-1:0] rgb_p2;
    logic          hsync_p2, vsync_p2;

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            rgb_p2   <= '0;
            hsync_p2 <= H_SYNC_IDLE;
            vsync_p2 <= V_SYNC_IDLE;
        end else begin
            rgb_p2   <= (vld_p1 && in_box_p1) ? box_color : '0;
            hsync_p2 <= hsync_p1;
            vsync_p2 <= vsync_p1;
        end
    end

    assign vga_r               = rgb_p2[CW-1 -: COLOR_BIT_DEPTH];
    assign vga_g               = rgb_p2[2*COLOR_BIT_DEPTH-1 -: COLOR_BIT_DEPTH];
    assign vga_b               = rgb_p2[COLOR_BIT_DEPTH-1:0];
    assign vga_horizontal_sync = hsync_p2;
    assign vga_vertical_sync   = vsync_p2;

endmodule
